stream_subtractor: RTL and testbench

- Streaming elementwise subtractor for the tinygrad elementwise datapath; computes out = a - b per element.
- Produces a WIDTH+1-bit two's-complement difference plus a borrow flag. This is the inverse of the 9-bit-sum adder path.
- Sits between operand fetch and writeback. Uses valid/ready handshakes on both sides, a registered compute stage and a small output buffer.
- Keeps per-packet statistics (element count, borrow count), delimited by a last flag.

---
 rtl/sub_pkg.sv | 24 ++
 rtl/sub_out_fifo.sv | 69 ++++++
 rtl/stream_subtractor.sv | 119 +++++++++++
 tb/tb_stream_subtractor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared defaults, FIFO entry type and pointer helper for stream_subtractor
package sub_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 2;
  localparam int unsigned DEF_COUNT_W = 16;

  typedef struct packed {
    logic                 last;
    logic                 borrow;
    logic [DEF_WIDTH:0]   diff;
  } fifo_entry_t;

  // Modulo-depth increment so non-power-of-two depths wrap correctly.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt;
    nxt = ptr + 1;
    if (nxt == depth) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sub_out_fifo.sv
// rtl/sub_out_fifo.sv - generic synchronous FIFO with registered occupancy
module sub_out_fifo
  import sub_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter type         T     = fifo_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = PW'(ptr_next(32'(wr_ptr_q), DEPTH));
    end
    if (do_pop) begin
      rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), DEPTH));
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/stream_subtractor.sv
// rtl/stream_subtractor.sv - streaming a - b with borrow, output FIFO and per-packet statistics
module stream_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_diff,
  output logic               out_borrow,
  output logic               out_last,
  output logic               pkt_done,
  output logic [COUNT_W-1:0] pkt_len,
  output logic [COUNT_W-1:0] pkt_borrows
);

  typedef struct packed {
    logic           last;
    logic           borrow;
    logic [WIDTH:0] diff;
  } entry_t;

  entry_t in_entry, head;
  logic   fifo_full, fifo_empty, accept, pop;

  logic [COUNT_W-1:0] elem_cnt_q, elem_cnt_d;
  logic [COUNT_W-1:0] borrow_cnt_q, borrow_cnt_d;
  logic [COUNT_W-1:0] pkt_len_q, pkt_len_d;
  logic [COUNT_W-1:0] pkt_borrows_q, pkt_borrows_d;
  logic               pkt_done_q, pkt_done_d;
  logic [COUNT_W-1:0] elem_inc, borrow_inc;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // Ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready = !fifo_full && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_entry        = '0;
    in_entry.diff   = {1'b0, in_a} - {1'b0, in_b};
    in_entry.borrow = in_entry.diff[WIDTH];
    in_entry.last   = in_last;
  end

  sub_out_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign out_diff   = head.diff;
  assign out_borrow = head.borrow;
  assign out_last   = head.last;

  always_comb begin
    elem_cnt_d    = elem_cnt_q;
    borrow_cnt_d  = borrow_cnt_q;
    pkt_len_d     = pkt_len_q;
    pkt_borrows_d = pkt_borrows_q;
    pkt_done_d    = 1'b0;
    elem_inc      = sat_inc(elem_cnt_q);
    borrow_inc    = in_entry.borrow ? sat_inc(borrow_cnt_q) : borrow_cnt_q;
    if (accept) begin
      if (in_last) begin
        pkt_done_d    = 1'b1;
        pkt_len_d     = elem_inc;
        pkt_borrows_d = borrow_inc;
        elem_cnt_d    = '0;
        borrow_cnt_d  = '0;
      end else begin
        elem_cnt_d    = elem_inc;
        borrow_cnt_d  = borrow_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_cnt_q    <= '0;
      borrow_cnt_q  <= '0;
      pkt_len_q     <= '0;
      pkt_borrows_q <= '0;
      pkt_done_q    <= 1'b0;
    end else begin
      elem_cnt_q    <= elem_cnt_d;
      borrow_cnt_q  <= borrow_cnt_d;
      pkt_len_q     <= pkt_len_d;
      pkt_borrows_q <= pkt_borrows_d;
      pkt_done_q    <= pkt_done_d;
    end
  end

  assign pkt_done    = pkt_done_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_borrows = pkt_borrows_q;

endmodule

// File: tb/tb_stream_subtractor.sv
// tb/tb_stream_subtractor.sv - scoreboard bench for stream_subtractor
module tb_stream_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_a, in_b;
  logic        out_valid, out_ready, out_borrow, out_last;
  logic [8:0]  out_diff;
  logic        pkt_done;
  logic [15:0] pkt_len, pkt_borrows;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;
  bit rand_mode = 1'b0;

  logic [9:0]  exp_q[$];
  logic [31:0] pkt_q[$];
  logic [15:0] m_len = 0, m_bor = 0;
  logic [15:0] last_len_seen = 0, last_bor_seen = 0;

  stream_subtractor dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_diff    (out_diff),
    .out_borrow  (out_borrow),
    .out_last    (out_last),
    .pkt_done    (pkt_done),
    .pkt_len     (pkt_len),
    .pkt_borrows (pkt_borrows)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected results and packet stats whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got diff %0h with empty scoreboard", out_diff);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("out_diff", 32'(out_diff), 32'(e[8:0]));
          check("out_borrow", 32'(out_borrow), 32'(e[8]));
          check("out_last", 32'(out_last), 32'(e[9]));
        end
      end
      if (pkt_done) begin
        if (pkt_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pkt_done: got len %0d with no packet pending", pkt_len);
        end else begin
          logic [31:0] p;
          p = pkt_q.pop_front();
          check("pkt_len", 32'(pkt_len), 32'(p[31:16]));
          check("pkt_borrows", 32'(pkt_borrows), 32'(p[15:0]));
        end
        last_len_seen = pkt_len;
        last_bor_seen = pkt_borrows;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                      input logic [8:0] exp_diff);
    int w;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
    end else begin
      stall_cnt += w;
      exp_q.push_back({last, exp_diff});
      m_len = (m_len == 16'hFFFF) ? m_len : m_len + 16'd1;
      if (exp_diff[8]) m_bor = (m_bor == 16'hFFFF) ? m_bor : m_bor + 16'd1;
      if (last) begin
        pkt_q.push_back({m_len, m_bor});
        m_len = 0;
        m_bor = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || pkt_q.size() != 0) && w < 500) begin
      @(posedge clk);
      w++;
    end
    check("drain_exp", 32'(exp_q.size()), 0);
    check("drain_pkt", 32'(pkt_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] rd;
    logic       rl;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 0;
    in_b = 0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_diff", 32'(out_diff), 0);
    check("rst_out_borrow", 32'(out_borrow), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_pkt_done", 32'(pkt_done), 0);
    check("rst_pkt_len", 32'(pkt_len), 0);
    check("rst_pkt_borrows", 32'(pkt_borrows), 0);
    check("in_ready_after_reset", 32'(in_ready), 1);

    // Single-element packet: latency and pkt_done pulse.
    out_ready = 1'b1;
    send(8'd200, 8'd55, 1'b1, 9'd145);
    idle();
    check("lat_out_valid", 32'(out_valid), 1);
    check("lat_out_diff", 32'(out_diff), 32'd145);
    check("lat_pkt_done", 32'(pkt_done), 1);
    check("lat_pkt_len", 32'(pkt_len), 1);
    check("lat_pkt_borrows", 32'(pkt_borrows), 0);
    @(posedge clk);
    #1;
    check("pkt_done_one_cycle", 32'(pkt_done), 0);
    check("empty_after_pop", 32'(out_valid), 0);
    drain();

    // Negative and extreme differences.
    send(8'd3, 8'd10, 1'b0, 9'h1F9);
    send(8'd0, 8'd255, 1'b0, 9'h101);
    send(8'd255, 8'd0, 1'b1, 9'h0FF);
    idle();
    drain();
    check("pkt3_len", 32'(last_len_seen), 3);
    check("pkt3_borrows", 32'(last_bor_seen), 2);

    // Four-element stream at full rate.
    stall_cnt = 0;
    send(8'd10, 8'd3, 1'b0, 9'd7);
    send(8'd1, 8'd2, 1'b0, 9'h1FF);
    send(8'd7, 8'd7, 1'b0, 9'd0);
    send(8'd0, 8'd1, 1'b1, 9'h1FF);
    idle();
    check("stream_no_stall", 32'(stall_cnt), 0);
    drain();
    check("pkt4_len", 32'(last_len_seen), 4);
    check("pkt4_borrows", 32'(last_bor_seen), 2);

    // Back-to-back last elements.
    send(8'd1, 8'd1, 1'b1, 9'd0);
    send(8'd2, 8'd1, 1'b1, 9'd1);
    idle();
    drain();
    check("b2b_last_len", 32'(last_len_seen), 1);

    // Backpressure: only DEPTH elements enter, head held stable.
    out_ready = 1'b0;
    send(8'd50, 8'd20, 1'b0, 9'd30);
    send(8'd20, 8'd50, 1'b0, 9'h1E2);
    in_a = 8'd99;
    in_b = 8'd1;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_head_hold", 32'(out_diff), 32'd30);
    end
    @(posedge clk);
    #1;
    idle();
    out_ready = 1'b1;
    drain();

    // Reset mid-packet with one result buffered.
    out_ready = 1'b0;
    send(8'd5, 8'd1, 1'b0, 9'd4);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pkt_q.delete();
    m_len = 0;
    m_bor = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_pkt_len", 32'(pkt_len), 0);
    check("midrst_pkt_borrows", 32'(pkt_borrows), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    send(8'd9, 8'd4, 1'b0, 9'd5);
    send(8'd4, 8'd9, 1'b1, 9'h1FB);
    idle();
    drain();
    check("post_rst_pkt_len", 32'(last_len_seen), 2);
    check("post_rst_pkt_borrows", 32'(last_bor_seen), 1);

    // Random valid/ready traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rd = {1'b0, ra} - {1'b0, rb};
      rl = ($urandom_range(0, 7) == 0) || (i == 999);
      send(ra, rb, rl, rd);
    end
    idle();
    drain();
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
